// File: rtl/zorg_pkg.sv
// Shared widths, types and slicing helper for the shape-pattern guessing game.
package zorg_pkg;

   localparam int unsigned SHAPE_W   = 3;
   localparam int unsigned NUM_POS   = 4;
   localparam int unsigned PATTERN_W = 12;
   localparam int unsigned NUM_CODES = 8;

   typedef logic [SHAPE_W-1:0]   shape_t;
   typedef logic [3:0]           score_t;
   typedef logic [PATTERN_W-1:0] pattern_t;

   // Position 0 occupies the least-significant shape field.
   function automatic shape_t get_shape(input pattern_t pat, input int unsigned p);
      return pat[p*SHAPE_W +: SHAPE_W];
   endfunction

endpackage

// File: rtl/check_for_zood_if.sv
// Score-request bus between guess entry (master) and the scorer (slave).
interface check_for_zood_if;
   import zorg_pkg::*;

   logic     check;
   pattern_t masterPattern;
   pattern_t guess;
   score_t   Znarly;
   score_t   Zood;
   logic     scoreValid;

   modport master (
      output check, masterPattern, guess,
      input  Znarly, Zood, scoreValid
   );

   modport slave (
      input  check, masterPattern, guess,
      output Znarly, Zood, scoreValid
   );

endinterface

// File: rtl/check_for_znarly.sv
// Combinational exact-match count; also used standalone for game-over (Znarly == 4).
module check_for_znarly
   import zorg_pkg::*;
(
   input  pattern_t masterPattern,
   input  pattern_t guess,
   output score_t   Znarly
);

   logic [2:0] cnt;

   always_comb begin
      cnt = '0;
      for (int unsigned p = 0; p < NUM_POS; p++) begin
         if (get_shape(masterPattern, p) == get_shape(guess, p)) begin
            cnt = cnt + 3'd1;
         end
      end
   end

   assign Znarly = {1'b0, cnt};

endmodule

// File: rtl/check_for_zood.sv
// Guess scorer: registers exact (Znarly) and misplaced (Zood) match counts on a check strobe.
module check_for_zood
   import zorg_pkg::*;
(
   input logic             clock,
   input logic             reset_L,
   check_for_zood_if.slave bus
);

   score_t     znarly_d;
   score_t     zood_d;
   logic [2:0] total;
   logic [2:0] m_cnt [NUM_CODES];
   logic [2:0] g_cnt [NUM_CODES];

   score_t znarly_q, zood_q;
   logic   valid_q;

   check_for_znarly u_znarly (
      .masterPattern (bus.masterPattern),
      .guess         (bus.guess),
      .Znarly        (znarly_d)
   );

   always_comb begin
      for (int unsigned c = 0; c < NUM_CODES; c++) begin
         m_cnt[c] = '0;
         g_cnt[c] = '0;
         for (int unsigned p = 0; p < NUM_POS; p++) begin
            if (get_shape(bus.masterPattern, p) == shape_t'(c)) m_cnt[c] = m_cnt[c] + 3'd1;
            if (get_shape(bus.guess, p) == shape_t'(c))         g_cnt[c] = g_cnt[c] + 3'd1;
         end
      end
   end

   // Each shape instance matches at most once: sum of per-code minimums.
   always_comb begin
      total = '0;
      for (int unsigned c = 0; c < NUM_CODES; c++) begin
         total = total + ((m_cnt[c] < g_cnt[c]) ? m_cnt[c] : g_cnt[c]);
      end
   end

   // Exact matches are a subset of total matches, so this never underflows.
   assign zood_d = {1'b0, total} - znarly_d;

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         znarly_q <= '0;
         zood_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         valid_q <= bus.check;
         if (bus.check) begin
            znarly_q <= znarly_d;
            zood_q   <= zood_d;
         end
      end
   end

   assign bus.Znarly     = znarly_q;
   assign bus.Zood       = zood_q;
   assign bus.scoreValid = valid_q;

endmodule

// File: tb/tb_check_for_zood.sv
// Directed bench for check_for_zood and standalone check_for_znarly.
module tb_check_for_zood;
   import zorg_pkg::*;

   logic     clock;
   logic     reset_L;
   pattern_t sa_master, sa_guess;
   score_t   sa_znarly;
   int       tests = 0;
   int       fails = 0;

   check_for_zood_if bus ();

   check_for_zood dut (
      .clock   (clock),
      .reset_L (reset_L),
      .bus     (bus.slave)
   );

   check_for_znarly u_sa (
      .masterPattern (sa_master),
      .guess         (sa_guess),
      .Znarly        (sa_znarly)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_score(input string tag, input logic [3:0] zn, input logic [3:0] zo,
                            input logic v);
      chk({tag, ".znarly"}, bus.Znarly, zn);
      chk({tag, ".zood"}, bus.Zood, zo);
      chk({tag, ".valid"}, {3'b0, bus.scoreValid}, {3'b0, v});
   endtask

   task automatic score(input pattern_t m, input pattern_t g);
      bus.masterPattern = m;
      bus.guess         = g;
      bus.check         = 1'b1;
      tick();
   endtask

   initial begin
      reset_L           = 1'b0;
      bus.check         = 1'b0;
      bus.masterPattern = '0;
      bus.guess         = '0;
      sa_master         = '0;
      sa_guess          = '0;
      #2;
      chk_score("reset_init", 4'd0, 4'd0, 1'b0);
      // check asserted during reset is ignored
      bus.check = 1'b1;
      tick();
      chk_score("reset_check_ignored", 4'd0, 4'd0, 1'b0);
      reset_L = 1'b1;

      score(12'b001001001001, 12'b001001001001);
      chk_score("all_same", 4'd4, 4'd0, 1'b1);

      // asynchronous clear mid-cycle with check high
      reset_L = 1'b0;
      #1;
      chk_score("reset_async", 4'd0, 4'd0, 1'b0);
      #1;
      reset_L = 1'b1;
      score(12'b001010011100, 12'b001010011100);
      chk_score("post_reset", 4'd4, 4'd0, 1'b1);

      score(12'b001010011100, 12'b100010011001);
      chk_score("misplaced_2_2", 4'd2, 4'd2, 1'b1);
      score(12'b001010011100, 12'b100001010011);
      chk_score("misplaced_0_4", 4'd0, 4'd4, 1'b1);

      score(12'b011001001001, 12'b001001001001);
      chk_score("dup_surplus", 4'd3, 4'd0, 1'b1);
      score(12'b001001010010, 12'b010010001001);
      chk_score("dup_swap", 4'd0, 4'd4, 1'b1);
      score(12'b001010011100, 12'b101101101101);
      chk_score("dup_none", 4'd0, 4'd0, 1'b1);

      sa_master = 12'b001010011100;
      sa_guess  = 12'b011010011100; #1; chk("znarly_3", sa_znarly, 4'd3);
      sa_guess  = 12'b011011011100; #1; chk("znarly_2", sa_znarly, 4'd2);
      sa_guess  = 12'b011011100100; #1; chk("znarly_1", sa_znarly, 4'd1);
      sa_guess  = 12'b011011100101; #1; chk("znarly_0", sa_znarly, 4'd0);
      sa_guess  = 12'b001010011100; #1; chk("znarly_4", sa_znarly, 4'd4);

      score(12'b001010011100, 12'b001010011100);
      chk_score("gate_first", 4'd4, 4'd0, 1'b1);
      bus.check = 1'b0;
      bus.guess = 12'b101101101101;
      tick();
      chk_score("gate_hold1", 4'd4, 4'd0, 1'b0);
      tick();
      chk_score("gate_hold2", 4'd4, 4'd0, 1'b0);
      bus.check = 1'b1;
      tick();
      chk_score("gate_pulse", 4'd0, 4'd0, 1'b1);
      bus.check = 1'b0;
      bus.guess = 12'b001010011100;
      tick();
      chk_score("gate_after", 4'd0, 4'd0, 1'b0);

      score(12'b001010011100, 12'b100010011001);
      chk_score("held_a", 4'd2, 4'd2, 1'b1);
      score(12'b001010011100, 12'b100001010011);
      chk_score("held_b", 4'd0, 4'd4, 1'b1);
      score(12'b001010011100, 12'b001010011100);
      chk_score("held_c", 4'd4, 4'd0, 1'b1);
      score(12'b001010011100, 12'b101101101101);
      chk_score("held_d", 4'd0, 4'd0, 1'b1);
      bus.check = 1'b0;
      tick();
      chk_score("held_release", 4'd0, 4'd0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/check_for_zood.md
# check_for_zood

Guess-scoring block for the shape-pattern guessing game. It compares a 4-position guess against the stored master pattern. It produces two counts:
- Znarly: right shape in the right position.
- Zood: right shape in the wrong position.

Scores are registered on a `check` strobe. The block sits between the master-pattern loader / guess entry logic and the score display / game-over logic.

## Interface
Parameters: none; widths come from the shared package.
- `clock` input 1: system clock, rising-edge active.
- `reset_L` input 1: asynchronous, active-low reset.
- `check` input 1: score request, sampled on rising edge of `clock`.
- `masterPattern` input 12: four 3-bit shapes; position 3 = [11:9], 2 = [8:6], 1 = [5:3], 0 = [2:0].
- `guess` input 12: same layout as `masterPattern`.
- `Znarly` output 4: registered unsigned count of exact matches, 0..4.
- `Zood` output 4: registered unsigned count of misplaced matches, 0..4.
- `scoreValid` output 1: one-cycle pulse marking that the registered scores were just updated.

## Operation
- **Shape codes:** every 3-bit code 000..111 is a distinct literal symbol. No code is treated as blank or wildcard.
- **Znarly:** number of positions p (0..3) where `masterPattern[p] == guess[p]`.
- **Total matches:** sum over all 8 codes c of min(count of c in `masterPattern`, count of c in `guess`). Each shape instance is matched at most once.
- **Zood:** total matches minus Znarly. It never underflows, and Znarly + Zood ≤ 4.
- **Worked values:**
  - master 001001001001 vs guess 001001001001 → Znarly 4, Zood 0.
  - master 011001001001 vs guess 001001001001 → Znarly 3, Zood 0. The surplus 001 in the guess does not score.
  - master 001010011100 vs guess 100010011001 → Znarly 2, Zood 2.
- **Score computation:** combinational from the current `masterPattern` and `guess`. Internal arithmetic uses 3-bit counts, zero-extended to 4 bits on output.
- **Register update:** on a rising edge with `check`=1, `Znarly` and `Zood` load the computed values and `scoreValid`=1 for the following cycle.
  - With `check`=0, scores hold and `scoreValid`=0.
  - Holding `check` high re-scores every cycle and keeps `scoreValid` high.
- **Reset:** `reset_L`=0 immediately forces `Znarly`=0, `Zood`=0, `scoreValid`=0, regardless of `clock`.
  - An asserted `check` during reset is ignored.
  - The first edge after release with `check`=1 scores normally.
- **Input changes:** changes to `masterPattern`/`guess` without `check` do not alter outputs.

## Timing
- Latency 1 cycle: inputs and `check` are sampled at edge N; outputs are valid after edge N until the next scoring edge or reset.
- The combinational path must settle within one clock period. There is no multicycle path.
- `masterPattern` and `guess` must be stable around the sampling edge only. No hold beyond the edge is required.
- No handshake or backpressure; `check` is a level sampled per cycle.
- **Reset mid-operation:** asynchronous clear wins over a simultaneous `check`.

## Structure
- **Shared package `zorg_pkg`:**
  - `SHAPE_W`=3, `NUM_POS`=4, `PATTERN_W`=12.
  - `typedef logic [SHAPE_W-1:0] shape_t`.
  - `typedef logic [3:0] score_t`.
  - A slicing function returning shape_t for position p.
- **Sub-module `check_for_znarly`:** purely combinational, taking (`masterPattern`, `guess`) and producing the 4-bit exact-match count.
  - Instantiated inside `check_for_zood`.
  - Also usable standalone by the game-over detector (Znarly==4).
- **Zood / total-match logic:** per-code occurrence counters for each of the 8 codes, plus an 8-way min-and-sum, kept in the top module.

## Test plan
- **Reset:** assert `reset_L`=0 mid-run with `check`=1 → `Znarly`=0, `Zood`=0, `scoreValid`=0 immediately; release and score master 001010011100 vs guess 001010011100 → 4 / 0.
- **Exact-match sweep** on `check_for_znarly` alone, master 001010011100:
  - guess 011010011100 → 3;
  - guess 011011011100 → 2;
  - guess 011011100100 → 1;
  - guess 011011100101 → 0.
- **Misplaced shapes:** master 001010011100 vs guess 100010011001 → Znarly 2, Zood 2; guess 100001010011 → Znarly 0, Zood 4.
- **Duplicates:**
  - master 011001001001 vs guess 001001001001 → 3 / 0;
  - master 001001010010 vs guess 010010001001 → 0 / 4;
  - master 001010011100 vs guess 101101101101 → 0 / 0.
- **Check gating:** score once (4 / 0), then change `guess` to 101101101101 with `check`=0 for 2 cycles → outputs stay 4 / 0 and `scoreValid`=0; pulse `check` → 0 / 0 one edge later, `scoreValid` high for exactly one cycle.
- **Held check:** keep `check`=1 while toggling `guess` each cycle → scores track each cycle's guess with 1-cycle latency; `scoreValid` stays 1.
